zintack: RTL and testbench

- Z80-side counterpart of the frame INT generator: a multi-source IM2 interrupt controller.
- Merges per-source interrupt request pulses into one active-low /INT.
- Answers the Z80 interrupt-acknowledge cycle (M1+IORQ) by presenting a vector byte.
- Tracks in-service sources and retires them on a snooped RETI (ED 4D), allowing priority nesting.
- Sits in the z80 block between the event sources (frame, timers, peripherals) and the CPU data-bus mux.

---
 rtl/zintack_if.sv | 17 +
 rtl/zintack.sv | 105 ++++++++++
 tb/tb_zintack.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/zintack_if.sv
// zintack_if: Z80-side bus bundle between the CPU pins and the IM2 interrupt controller
//   master: drives zpos/zneg strobes, /M1 /IORQ /MREQ /RD and din; reads /INT and the vector byte
//   slave : the interrupt controller, reads the bus and drives int_n, vec_oe, vec_dout
interface zintack_if;
  logic zpos;
  logic zneg;
  logic m1_n;
  logic iorq_n;
  logic mreq_n;
  logic rd_n;
  logic [7:0] din;
  logic int_n;
  logic vec_oe;
  logic [7:0] vec_dout;
  modport master (output zpos, zneg, m1_n, iorq_n, mreq_n, rd_n, din, input int_n, vec_oe, vec_dout);
  modport slave (input zpos, zneg, m1_n, iorq_n, mreq_n, rd_n, din, output int_n, vec_oe, vec_dout);
endinterface

// File: rtl/zintack.sv
// zintack: multi-source IM2 interrupt controller with INTACK vector and RETI-snooped nesting
//   fclk, rst_n : system clock, async active-low reset
//   z           : Z80 bus (strobes, control, opcode snoop in; /INT, vector byte and its enable out)
//   int_req     : per-source one-fclk request pulses, index 0 highest priority
//   int_mask    : per-source enable
//   vec_base    : IM2 vector base, source i answers vec_base + 2*i
//   in_service  : sources acknowledged and not yet retired by RETI
module zintack #(
  parameter int NSRC = 4,
  parameter int TMO = 128
) (
  input logic fclk,
  input logic rst_n,
  zintack_if.slave z,
  input logic [NSRC-1:0] int_req,
  input logic [NSRC-1:0] int_mask,
  input logic [7:0] vec_base,
  output logic [NSRC-1:0] in_service
);
  localparam int IW = $clog2(NSRC);
  localparam int CW = TMO > 1 ? $clog2(TMO) : 1;
  typedef enum logic {A_IDLE, A_ACK} ack_t;
  typedef enum logic [1:0] {R_IDLE, R_ED, R_RETI} reti_t;
  ack_t a_st, a_nx;
  reti_t r_st, r_nx;
  logic [NSRC-1:0] pending, pending_nx, in_service_nx, allow, cand, clr, isr_set, reti_clr;
  logic [IW-1:0] elig_idx, ack_idx;
  logic elig_any, ack_valid, blk;
  logic [CW-1:0] cnt;
  logic cnt_en, tmo_hit, ack_start, ack_end;
  logic fetch, eval, m1_q, fetch_seen;
  logic [7:0] op_lat;
  // a source may only interrupt if it outranks every source already in service
  always_comb begin
    blk = 1'b0;
    allow = '0;
    for (int i = 0; i < NSRC; i++) begin
      blk = blk | in_service[i];
      allow[i] = ~blk;
    end
    cand = pending & int_mask & allow;
    elig_any = |cand;
    elig_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (cand[i]) elig_idx = IW'(i);
  end
  always_comb begin
    ack_start = a_st == A_IDLE && !z.iorq_n && !z.m1_n && z.zneg;
    ack_end = a_st == A_ACK && z.iorq_n;
    a_nx = ack_start ? A_ACK : ack_end ? A_IDLE : a_st;
    cnt_en = !z.int_n && a_st == A_IDLE;
    // drop the asserting source on the cycle the counter would reach TMO-1
    tmo_hit = TMO != 0 && cnt_en && elig_any && int'(cnt) + 1 >= TMO - 1;
    isr_set = ack_end && ack_valid ? NSRC'(1) << ack_idx : '0;
    clr = isr_set | (tmo_hit ? NSRC'(1) << elig_idx : '0);
    pending_nx = (pending & ~clr) | int_req;
    // x & -x isolates the lowest set in-service bit, the one RETI retires
    reti_clr = r_st == R_RETI ? in_service & (~in_service + 1'b1) : '0;
    in_service_nx = (in_service & ~reti_clr) | isr_set;
  end
  // the INTACK M1 has /MREQ high, so it never counts as a fetch
  always_comb begin
    fetch = !z.m1_n && !z.mreq_n && !z.rd_n && z.iorq_n;
    eval = z.m1_n && !m1_q && fetch_seen;
    r_nx = r_st;
    if (r_st == R_RETI) r_nx = R_IDLE;
    else if (eval) r_nx = op_lat == 8'h4D && r_st == R_ED ? R_RETI : op_lat == 8'hED ? R_ED : R_IDLE;
  end
  always_ff @(posedge fclk or negedge rst_n)
    if (!rst_n) begin
      a_st <= A_IDLE;
      r_st <= R_IDLE;
    end else begin
      a_st <= a_nx;
      r_st <= r_nx;
    end
  always_ff @(posedge fclk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      in_service <= '0;
      z.int_n <= 1'b1;
      z.vec_oe <= 1'b0;
      z.vec_dout <= 8'hFF;
      cnt <= '0;
      ack_idx <= '0;
      ack_valid <= 1'b0;
      m1_q <= 1'b1;
      fetch_seen <= 1'b0;
      op_lat <= 8'h00;
    end else begin
      pending <= pending_nx;
      in_service <= in_service_nx;
      z.int_n <= !(elig_any && a_st == A_IDLE);
      z.vec_oe <= ack_start || (a_st == A_ACK && !z.iorq_n && !z.m1_n);
      if (ack_start) begin
        ack_idx <= elig_idx;
        ack_valid <= elig_any;
        z.vec_dout <= elig_any ? vec_base + 8'({elig_idx, 1'b0}) : 8'hFF;
      end
      cnt <= cnt_en && !tmo_hit ? cnt + 1'b1 : '0;
      m1_q <= z.m1_n;
      fetch_seen <= !z.m1_n && (fetch_seen || (z.zpos && fetch));
      if (z.zpos && fetch) op_lat <= z.din;
    end
endmodule

// File: tb/tb_zintack.sv
// tb_zintack: directed and random stimulus for zintack against a cycle-level behavioural model
module tb_zintack;
  localparam int NSRC = 4;
  localparam int TMO = 128;
  logic fclk = 1'b0;
  logic rst_n;
  logic [NSRC-1:0] int_req, int_mask, in_service;
  logic [7:0] vec_base;
  zintack_if zb();
  zintack #(.NSRC(NSRC), .TMO(TMO)) dut (
    .fclk(fclk),
    .rst_n(rst_n),
    .z(zb),
    .int_req(int_req),
    .int_mask(int_mask),
    .vec_base(vec_base),
    .in_service(in_service)
  );
  always #5 fclk = ~fclk;
  int checks = 0;
  int errors = 0;
  bit [NSRC-1:0] m_pend, m_isr;
  bit m_intn, m_voe, m_ack, m_reti, m_seen, m_m1;
  bit [7:0] m_vd, m_op, m_last;
  int m_aidx, m_cnt;
  logic [7:0] v;
  logic oe;
  int low;
  logic [7:0] ops [4];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pend = '0; m_isr = '0; m_intn = 1; m_voe = 0; m_vd = 8'hFF; m_ack = 0; m_aidx = -1;
    m_cnt = 0; m_reti = 0; m_seen = 0; m_m1 = 1; m_op = 0; m_last = 0;
  endtask
  // one fclk of spec behaviour, evaluated on the inputs about to be sampled
  task automatic model_step();
    int e, lim;
    bit start, fin, eval, fetch;
    bit [NSRC-1:0] np, ni;
    e = -1; lim = NSRC;
    for (int i = NSRC - 1; i >= 0; i--) if (m_isr[i]) lim = i;
    for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i] && int_mask[i] && i < lim) e = i;
    start = !m_ack && !zb.iorq_n && !zb.m1_n && zb.zneg;
    fin = m_ack && zb.iorq_n;
    np = m_pend; ni = m_isr;
    if (m_reti)
      for (int i = 0; i < NSRC; i++) if (m_isr[i]) begin ni[i] = 0; break; end
    if (fin && m_aidx >= 0) begin np[m_aidx] = 0; ni[m_aidx] = 1; end
    if (!m_intn && !m_ack) begin
      if (e >= 0 && m_cnt + 1 >= TMO - 1) begin np[e] = 0; m_cnt = 0; end
      else m_cnt++;
    end else m_cnt = 0;
    np = np | int_req;
    m_voe = start || (m_ack && !zb.iorq_n && !zb.m1_n);
    if (start) begin
      m_aidx = e;
      m_vd = e >= 0 ? 8'(int'(vec_base) + 2 * e) : 8'hFF;
    end
    m_intn = !(e >= 0 && !m_ack);
    m_ack = start ? 1'b1 : fin ? 1'b0 : m_ack;
    fetch = !zb.m1_n && !zb.mreq_n && !zb.rd_n && zb.iorq_n;
    eval = zb.m1_n && !m_m1 && m_seen;
    m_reti = eval && m_last == 8'hED && m_op == 8'h4D;
    if (eval) m_last = m_op;
    if (zb.m1_n) m_seen = 0;
    else if (zb.zpos && fetch) begin m_seen = 1; m_op = zb.din; end
    m_m1 = zb.m1_n;
    m_pend = np; m_isr = ni;
  endtask
  task automatic cyc();
    model_step();
    @(posedge fclk);
    @(negedge fclk);
    check("int_n", zb.int_n, m_intn);
    check("vec_oe", zb.vec_oe, m_voe);
    check("vec_dout", zb.vec_dout, m_vd);
    check("in_service", in_service, m_isr);
  endtask
  task automatic tst();
    zb.zpos = 1; cyc(); zb.zpos = 0; cyc(); zb.zneg = 1; cyc(); zb.zneg = 0; cyc();
  endtask
  task automatic fetch(input logic [7:0] op);
    zb.m1_n = 0; zb.mreq_n = 0; zb.rd_n = 0; zb.din = op; tst(); tst();
    zb.m1_n = 1; zb.mreq_n = 1; zb.rd_n = 1; zb.din = 8'h00; tst(); tst();
  endtask
  task automatic intack(input logic [NSRC-1:0] req_end, output logic [7:0] vec, output logic vo);
    zb.m1_n = 0; tst(); tst(); zb.iorq_n = 0; tst();
    vo = zb.vec_oe; vec = zb.vec_dout;
    tst();
    zb.m1_n = 1; zb.iorq_n = 1; int_req = req_end; cyc(); int_req = '0; cyc(); cyc(); cyc();
  endtask
  task automatic pulse(input int i);
    int_req[i] = 1'b1; cyc(); int_req = '0;
  endtask
  initial begin
    ops[0] = 8'hED; ops[1] = 8'h4D; ops[2] = 8'h00; ops[3] = 8'hED;
    rst_n = 0; int_req = '0; int_mask = '1; vec_base = 8'h80;
    zb.zpos = 0; zb.zneg = 0; zb.m1_n = 1; zb.iorq_n = 1; zb.mreq_n = 1; zb.rd_n = 1; zb.din = 8'h00;
    model_reset();
    repeat (3) @(negedge fclk);
    check("rst_int_n", zb.int_n, 1);
    check("rst_vec_oe", zb.vec_oe, 0);
    check("rst_vec_dout", zb.vec_dout, 8'hFF);
    check("rst_isr", in_service, 0);
    rst_n = 1;
    cyc();
    pulse(2);
    check("t1_int_n_pre", zb.int_n, 1);
    cyc();
    check("t1_int_n_low", zb.int_n, 0);
    intack('0, v, oe);
    check("t1_oe", oe, 1);
    check("t1_vec", v, 8'h84);
    check("t1_isr", in_service, 4'b0100);
    check("t1_int_n_hi", zb.int_n, 1);
    pulse(0); cyc();
    intack('0, v, oe);
    check("t2_vec", v, 8'h80);
    check("t2_isr", in_service, 4'b0101);
    fetch(8'hED); fetch(8'h4D); cyc();
    check("t2_reti", in_service, 4'b0100);
    fetch(8'hED); fetch(8'h00); fetch(8'h4D); cyc();
    check("t2_broken", in_service, 4'b0100);
    fetch(8'hED); fetch(8'hED); fetch(8'h4D); cyc();
    check("t2_eded", in_service, 4'b0000);
    pulse(2); cyc();
    intack('0, v, oe);
    pulse(3); repeat (3) cyc();
    check("t3_blocked", zb.int_n, 1);
    pulse(1); cyc();
    check("t3_nest", zb.int_n, 0);
    intack('0, v, oe);
    check("t3_vec", v, 8'h82);
    check("t3_isr", in_service, 4'b0110);
    fetch(8'hED); fetch(8'h4D);
    fetch(8'hED); fetch(8'h4D);
    check("t3_isr_clr", in_service, 4'b0000);
    intack('0, v, oe);
    check("t3_vec3", v, 8'h86);
    fetch(8'hED); fetch(8'h4D);
    pulse(0);
    low = 0;
    repeat (300) begin
      cyc();
      if (!zb.int_n) low++;
    end
    check("t4_low_cycles", low, 128);
    check("t4_int_n", zb.int_n, 1);
    intack('0, v, oe);
    check("t5_spur_vec", v, 8'hFF);
    check("t5_spur_oe", oe, 1);
    check("t5_spur_isr", in_service, 0);
    pulse(1); cyc();
    intack(4'b0010, v, oe);
    check("t5_vec", v, 8'h82);
    check("t5_isr", in_service, 4'b0010);
    fetch(8'hED); fetch(8'h4D);
    check("t5_repend", zb.int_n, 0);
    intack('0, v, oe);
    fetch(8'hED); fetch(8'h4D);
    check("t5_done", zb.int_n, 1);
    pulse(2); cyc();
    zb.m1_n = 0; tst(); tst(); zb.iorq_n = 0; tst();
    check("t6_oe_pre", zb.vec_oe, 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    check("t6_oe", zb.vec_oe, 0);
    check("t6_int_n", zb.int_n, 1);
    check("t6_isr", in_service, 0);
    @(negedge fclk);
    zb.m1_n = 1; zb.iorq_n = 1; zb.zpos = 0; zb.zneg = 0;
    rst_n = 1;
    repeat (3) cyc();
    check("t6_pend", zb.int_n, 1);
    repeat (250) begin
      case ($urandom_range(0, 6))
        0, 1: pulse($urandom_range(0, NSRC - 1));
        2: begin int_mask = NSRC'($urandom | $urandom); vec_base = 8'($urandom); cyc(); end
        3: fetch(ops[$urandom_range(0, 3)]);
        4: intack($urandom_range(0, 3) == 0 ? NSRC'($urandom) : '0, v, oe);
        5: repeat ($urandom_range(1, 40)) cyc();
        default: begin fetch(8'hED); fetch(8'h4D); end
      endcase
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
